// File: rtl/gray_monitor_pkg.sv
// Shared coding definitions for the Gray-code counter subsystem: monitor FSM
// state values, the default code width and the Gray-to-binary conversion, so
// the upstream counter and its monitor agree on coding.
package gray_monitor_pkg;

    // Default Gray/binary code width, matching the upstream counter.
    localparam int GRAY_W = 3;

    // Widest code the conversion helper supports.
    localparam int G2B_MAXW = 32;

    // Monitor FSM states. Code 2'd3 is never entered and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    // Gray-to-binary: the MSB passes straight through and every lower binary
    // bit is the XOR of the binary bit above it and its own Gray bit.
    // Narrower codes are zero-extended by the caller. Zero upper Gray bits
    // give zero upper binary bits, so the low bits come out unchanged.
    function automatic logic [G2B_MAXW-1:0] g2b(input logic [G2B_MAXW-1:0] g);
        logic [G2B_MAXW-1:0] b;
        b = '0;
        b[G2B_MAXW-1] = g[G2B_MAXW-1];
        for (int i = G2B_MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_monitor_gray_to_bin.sv
// Purely combinational W-bit Gray-to-binary converter built on the shared
// package function, so every user of the code sees the same mapping.
module gray_to_bin
    import gray_monitor_pkg::*;
#(
    parameter int W = GRAY_W
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    logic [G2B_MAXW-1:0] gray_ext;

    // Zero-extend the code to the helper's width before converting.
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        gray_ext         = '0;
        gray_ext[W-1:0]  = gray_i;
    end

    assign bin_o = W'(g2b(gray_ext));

endmodule

// File: rtl/gray_monitor.sv
// Gray-code step monitor. Samples the upstream Gray code when qualified,
// registers its binary value, checks that each step is a hold or a +1 (with
// wrap), counts completed laps and latches a sticky fault on an illegal step.
module gray_monitor
    import gray_monitor_pkg::*;
#(
    parameter int W    = GRAY_W,
    parameter int LAPW = 8
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Clear,
    input  logic            Sample,
    input  logic [W-1:0]    Gray,
    output logic [W-1:0]    Bin,
    output logic            Wrap,
    output logic [LAPW-1:0] Lap_count,
    output logic            Step_err,
    output logic            Err_sticky,
    output logic            Tracking
);

    state_t          state_q,      state_d;
    logic [W-1:0]    bin_q,        bin_d;
    logic            wrap_q,       wrap_d;
    logic [LAPW-1:0] lap_q,        lap_d;
    logic            step_err_q,   step_err_d;
    logic            err_sticky_q, err_sticky_d;

    logic [W-1:0]    nb;
    logic [W-1:0]    delta;
    logic            step_hold;
    logic            step_inc;
    logic            step_wrap;
    logic            lap_at_max;

    // Binary value of the code presented this cycle.
    gray_to_bin #(
        .W (W)
    ) u_gray_to_bin (
        .gray_i (Gray),
        .bin_o  (nb)
    );

    // Step classification against the last accepted value. The subtraction
    // wraps modulo 2^W, so 7 -> 0 is a +1 step just like 3 -> 4.
    assign delta      = nb - bin_q;
    assign step_hold  = (delta == '0);
    assign step_inc   = (delta == W'(1));
    assign step_wrap  = step_inc && (bin_q == {W{1'b1}}) && (nb == '0);
    assign lap_at_max = (lap_q == {LAPW{1'b1}});

    // State register; Reset is synchronous and beats every other input.
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from the values sampled at the same edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: Clear returns to IDLE and discards any Sample.
    always_comb begin
        state_d = state_q;
        if (Clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Sample) begin
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (Sample && !step_hold && !step_inc) begin
                        state_d = FAULT;
                    end
                end
                FAULT: begin
                    // Held here until Clear.
                    state_d = FAULT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output logic: next values for the registered outputs. Wrap and
    // Step_err are pulses and fall back to 0 unless set this cycle.
    always_comb begin
        bin_d        = bin_q;
        wrap_d       = 1'b0;
        lap_d        = lap_q;
        step_err_d   = 1'b0;
        err_sticky_d = err_sticky_q;
        if (Clear) begin
            err_sticky_d = 1'b0;
        end else if (Sample) begin
            case (state_q)
                IDLE: begin
                    // First sample seeds the reference; nothing to check yet.
                    bin_d = nb;
                end
                TRACK: begin
                    if (step_hold) begin
                        bin_d = bin_q;
                    end else if (step_inc) begin
                        bin_d = nb;
                        if (step_wrap) begin
                            wrap_d = 1'b1;
                            if (!lap_at_max) begin
                                lap_d = lap_q + LAPW'(1);
                            end
                        end
                    end else begin
                        bin_d        = nb;
                        step_err_d   = 1'b1;
                        err_sticky_d = 1'b1;
                    end
                end
                FAULT: begin
                    // Keep following the code, but stop judging it.
                    bin_d = nb;
                end
                default: begin
                    bin_d = bin_q;
                end
            endcase
        end
    end

    // Output registers, synchronously reset to zero.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bin_q        <= '0;
            wrap_q       <= 1'b0;
            lap_q        <= '0;
            step_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            bin_q        <= bin_d;
            wrap_q       <= wrap_d;
            lap_q        <= lap_d;
            step_err_q   <= step_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign Bin        = bin_q;
    assign Wrap       = wrap_q;
    assign Lap_count  = lap_q;
    assign Step_err   = step_err_q;
    assign Err_sticky = err_sticky_q;
    assign Tracking   = (state_q == TRACK);

endmodule

// File: tb/tb_gray_monitor.sv
// Scoreboard bench for gray_monitor: a driver applies directed and random
// stimulus and queues the expected registered response from a behavioural
// model; a monitor pops one entry per cycle and compares it with the DUT.
module tb_gray_monitor;

    localparam int W       = 3;
    localparam int LAPW    = 2;
    localparam int MODN    = 1 << W;
    localparam int LAP_MAX = (1 << LAPW) - 1;

    logic            Clk    = 1'b0;
    logic            Reset  = 1'b1;
    logic            Clear  = 1'b0;
    logic            Sample = 1'b0;
    logic [W-1:0]    Gray   = '0;
    logic [W-1:0]    Bin;
    logic            Wrap;
    logic [LAPW-1:0] Lap_count;
    logic            Step_err;
    logic            Err_sticky;
    logic            Tracking;

    int vectors     = 0;
    int miscompares = 0;

    gray_monitor #(
        .W    (W),
        .LAPW (LAPW)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Clear      (Clear),
        .Sample     (Sample),
        .Gray       (Gray),
        .Bin        (Bin),
        .Wrap       (Wrap),
        .Lap_count  (Lap_count),
        .Step_err   (Step_err),
        .Err_sticky (Err_sticky),
        .Tracking   (Tracking)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int bin;
        bit wrap;
        int lap;
        bit serr;
        bit sticky;
        bit trk;
    } exp_t;

    exp_t sb[$];

    // Reference model: mode 0 = waiting for first sample, 1 = tracking,
    // 2 = faulted.
    int m_mode   = 0;
    int m_bin    = 0;
    int m_lap    = 0;
    bit m_sticky = 1'b0;

    function automatic int b2g(input int n);
        return n ^ (n >> 1);
    endfunction

    // Inverse by search over all codes rather than by XOR chain.
    function automatic int g2i(input int g);
        for (int n = 0; n < MODN; n++) begin
            if (b2g(n) == g) return n;
        end
        return -1;
    endfunction

    task automatic apply(input bit rst, input bit clr, input bit smp, input int g);
        exp_t e;
        int   nb;
        @(negedge Clk);
        Reset  = rst;
        Clear  = clr;
        Sample = smp;
        Gray   = W'(g);
        e.wrap = 1'b0;
        e.serr = 1'b0;
        if (rst) begin
            m_mode = 0; m_bin = 0; m_lap = 0; m_sticky = 1'b0;
        end else if (clr) begin
            m_mode = 0; m_sticky = 1'b0;
        end else if (smp) begin
            nb = g2i(g);
            if (m_mode == 0) begin
                m_bin  = nb;
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (nb == (m_bin + 1) % MODN) begin
                    if (nb == 0) begin
                        e.wrap = 1'b1;
                        if (m_lap < LAP_MAX) m_lap++;
                    end
                    m_bin = nb;
                end else if (nb != m_bin) begin
                    e.serr   = 1'b1;
                    m_sticky = 1'b1;
                    m_mode   = 2;
                    m_bin    = nb;
                end
            end else begin
                m_bin = nb;
            end
        end
        e.bin    = m_bin;
        e.lap    = m_lap;
        e.sticky = m_sticky;
        e.trk    = (m_mode == 1);
        sb.push_back(e);
    endtask

    task automatic smp(input int g);
        apply(1'b0, 1'b0, 1'b1, g);
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic rst();
        apply(1'b1, 1'b0, 1'b0, 0);
    endtask

    // Monitor: every registered output is valid each cycle, so one entry is
    // consumed per clock once the driver has started queueing.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                vectors++;
                if ($isunknown({Bin, Wrap, Lap_count, Step_err, Err_sticky, Tracking}) ||
                    int'(Bin) != e.bin || Wrap !== e.wrap || int'(Lap_count) != e.lap ||
                    Step_err !== e.serr || Err_sticky !== e.sticky || Tracking !== e.trk) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got bin=%0d wrap=%b lap=%0d step_err=%b sticky=%b tracking=%b, expected bin=%0d wrap=%b lap=%0d step_err=%b sticky=%b tracking=%b",
                             $time, Bin, Wrap, Lap_count, Step_err, Err_sticky, Tracking,
                             e.bin, e.wrap, e.lap, e.serr, e.sticky, e.trk);
                end
            end
        end
    end

    initial begin : driver
        int cnt;
        int r;

        // Reset state.
        rst();
        rst();

        // Full legal lap 0..7 then wrap to 0.
        for (int n = 0; n <= MODN; n++) smp(b2g(n % MODN));

        // Holds and idle cycles while tracking at Gray 011.
        rst();
        for (int n = 0; n <= 2; n++) smp(b2g(n));
        repeat (3) smp(3'b011);
        repeat (2) idle();

        // Skip 001 -> 010, then legal steps in FAULT give no more errors.
        rst();
        smp(3'b000);
        smp(3'b001);
        smp(3'b010);
        for (int n = 4; n <= MODN; n++) smp(b2g(n % MODN));

        // Backward step, then Clear with a discarded Sample, then re-seed.
        rst();
        smp(3'b000);
        smp(3'b001);
        smp(3'b011);
        smp(3'b001);
        apply(1'b0, 1'b1, 1'b1, 3'b111);
        smp(3'b110);
        smp(3'b111);

        // Five legal laps: lap counter saturates at its maximum.
        rst();
        smp(b2g(0));
        for (int lap = 0; lap < 5; lap++) begin
            for (int n = 1; n <= MODN; n++) smp(b2g(n % MODN));
        end

        // Reset together with Clear and Sample mid-lap.
        smp(b2g(1));
        smp(b2g(2));
        apply(1'b1, 1'b1, 1'b1, b2g(3));
        smp(3'b101);
        smp(3'b100);

        // Randomised traffic around a mostly well-behaved upstream counter.
        cnt = 7;
        for (int i = 0; i < 800; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                rst();
            end else if (r < 5) begin
                apply(1'b0, 1'b1, 1'($urandom_range(0, 1)), b2g(cnt));
            end else if (r < 20) begin
                apply(1'b0, 1'b0, 1'b0, int'($urandom_range(0, MODN - 1)));
            end else begin
                r = int'($urandom_range(0, 99));
                if (r < 70)      cnt = (cnt + 1) % MODN;
                else if (r < 85) cnt = cnt;
                else             cnt = int'($urandom_range(0, MODN - 1));
                smp(b2g(cnt));
            end
        end
        idle();

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge Clk);
        #2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d entries still queued, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
